// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time and holds each
// returned instruction until the decoder accepts it. A redirect flushes
// the fetch in flight, and the pipeline then refetches from the target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DROP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        id_valid_nxt;
  logic [31:0] id_inst_nxt;
  logic [31:0] id_pc_nxt;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;

  // Redirect targets are forced word-aligned; pc+4 wraps naturally at 32 bits.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign pc_inc       = pc + 32'd4;

  // The request is gated by rst_n so it drops the instant reset asserts,
  // and by redirect so a stale address is never accepted.
  assign imem_req  = rst_n && (state == ST_REQ) && !redirect;
  assign imem_addr = pc;

  // State register, pc and decoder-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_inst  <= NOP;
      id_pc    <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      id_valid <= id_valid_nxt;
      id_inst  <= id_inst_nxt;
      id_pc    <= id_pc_nxt;
    end
  end

  // Next-state logic: redirect loads the pc in every state and wins over
  // both a grant and a decoder handshake; a response for an abandoned fetch
  // is swallowed in DROP so only one request is ever outstanding.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    id_valid_nxt = id_valid;
    id_inst_nxt  = id_inst;
    id_pc_nxt    = id_pc;

    if (redirect) begin
      pc_nxt = redirect_tgt;
    end

    case (state)
      ST_REQ: begin
        if (!redirect && imem_gnt) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          state_nxt = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid) begin
          state_nxt    = ST_OUT;
          id_valid_nxt = 1'b1;
          id_inst_nxt  = imem_rdata;
          id_pc_nxt    = pc;
          pc_nxt       = pc_inc;
        end
      end
      ST_OUT: begin
        if (redirect || id_ready) begin
          state_nxt    = ST_REQ;
          id_valid_nxt = 1'b0;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_nxt = ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_REQ;
      end
    endcase
  end

endmodule
